uart_rx_fifo_ctrl_p: RTL and testbench

//  Parametrised UART receive FIFO between the UART Rx controller and the DSP bus. It stores each received

---
 rtl/uart_rx_fifo_ctrl_p_if.sv | 10 +
 rtl/uart_rx_fifo_ctrl_p.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl_p.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_ctrl_p_if.sv
// DSP bus used by the UART receive FIFO: one access per cycle, registered read data.
interface uart_rx_fifo_ctrl_p_if;
    logic        DSP_CEn;
    logic        DSP_WEn;
    logic [3:0]  DSP_ADDR;
    logic [31:0] DSP_RDATA;

    modport master (output DSP_CEn, output DSP_WEn, output DSP_ADDR, input DSP_RDATA);
    modport slave  (input DSP_CEn, input DSP_WEn, input DSP_ADDR, output DSP_RDATA);
endinterface

// File: rtl/uart_rx_fifo_ctrl_p.sv
// UART receive FIFO between the Rx controller (async RxDone) and the DSP bus.
// Each entry holds {err[2:0], data}; status is derived from the read/write pointers,
// an error-entry counter, an idle timeout counter and a sticky overrun flag.
module uart_rx_fifo_ctrl_p #(
    parameter int         DATA_W      = 8,
    parameter int         DEPTH_LOG2  = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [3:0] RD_ADDR     = 4'h0,
    parameter logic [3:0] ST_ADDR     = 4'h1
) (
    input  logic                  DSP_CLK,
    input  logic                  RESETn,
    uart_rx_fifo_ctrl_p_if.slave  dsp,
    input  logic                  FIFOEn,
    input  logic                  FIFOClr,
    input  logic [1:0]            TrigSel,
    input  logic                  RxDone,
    input  logic [DATA_W-1:0]     RxData,
    input  logic [2:0]            RxErr,
    output logic [DEPTH_LOG2:0]   RxFIFO_Level,
    output logic                  RxFIFO_Empty,
    output logic                  RxFIFO_Full,
    output logic                  RxTrig,
    output logic                  RxTimeout,
    output logic                  OverrunError,
    output logic                  ErrInFIFO
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int EW    = DATA_W + 3;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_P = TW'(TIMEOUT_CYC);

    logic [SYNC_STAGES:0] r_sync;
    logic [PW-1:0]        r_wp;
    logic [PW-1:0]        r_rp;
    logic [PW-1:0]        r_errCnt;
    logic [TW-1:0]        r_toCnt;
    logic                 r_overrun;
    logic [31:0]          r_rdata;
    logic [EW-1:0]        r_mem [DEPTH];

    logic [PW-1:0]        w_level;
    logic [8:0]           w_level9;
    logic [PW-1:0]        w_effDepth;
    logic [PW-1:0]        w_trigLvl;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_timeout;
    logic                 w_pushReq;
    logic                 w_popReq;
    logic                 w_stReq;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_pushErr;
    logic                 w_popErr;
    logic [EW-1:0]        w_head;
    logic [31:0]          w_rdNext;

    assign w_level    = r_wp - r_rp;
    assign w_level9   = 9'(w_level);
    assign w_empty    = (w_level == '0);
    assign w_effDepth = FIFOEn ? DEPTH_P : PW'(1);
    assign w_full     = (w_level >= w_effDepth);
    assign w_timeout  = (r_toCnt == TIMEOUT_P) & ~w_empty;
    assign w_head     = r_mem[r_rp[DEPTH_LOG2-1:0]];

    assign w_pushReq  = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
    assign w_popReq   = ~dsp.DSP_CEn & dsp.DSP_WEn & (dsp.DSP_ADDR == RD_ADDR);
    assign w_stReq    = ~dsp.DSP_CEn & dsp.DSP_WEn & (dsp.DSP_ADDR == ST_ADDR);
    assign w_pop      = w_popReq & ~w_empty & ~FIFOClr;
    assign w_push     = w_pushReq & ~FIFOClr & (~w_full | w_pop);
    assign w_drop     = w_pushReq & ~FIFOClr & w_full & ~w_pop;
    assign w_pushErr  = w_push & (|RxErr);
    assign w_popErr   = w_pop & (|w_head[EW-1:DATA_W]);

    // Trigger threshold; a depth-1 holding register always triggers at one entry.
    always_comb begin
        w_trigLvl = PW'(1);
        if (FIFOEn) begin
            case (TrigSel)
                2'd1:    w_trigLvl = PW'(DEPTH / 4);
                2'd2:    w_trigLvl = PW'(DEPTH / 2);
                2'd3:    w_trigLvl = PW'(DEPTH - 2);
                default: w_trigLvl = PW'(1);
            endcase
        end
    end

    // Read-data mux: popped entry with valid bit 31, or the status snapshot, else zero.
    always_comb begin
        w_rdNext = '0;
        if (w_pop) begin
            w_rdNext[EW-1:0] = w_head;
            w_rdNext[31]     = 1'b1;
        end else if (w_stReq) begin
            w_rdNext[8:0] = w_level9;
            w_rdNext[9]   = w_empty;
            w_rdNext[10]  = w_full;
            w_rdNext[11]  = RxTrig;
            w_rdNext[12]  = ErrInFIFO;
            w_rdNext[13]  = w_timeout;
            w_rdNext[14]  = r_overrun;
        end
    end

    // Synchronise RxDone; the extra last flop provides the rising-edge detect.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-1:0], RxDone};
    end

    // Character storage is deliberately left unreset.
    always_ff @(posedge DSP_CLK) begin
        if (w_push) r_mem[r_wp[DEPTH_LOG2-1:0]] <= {RxErr, RxData};
    end

    // Pointer update; a flush discards everything by catching rp up to wp.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (FIFOClr) begin
            r_rp <= r_wp;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
        end
    end

    // Count of held entries carrying an error, so ErrInFIFO needs no scan of storage.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn)                     r_errCnt <= '0;
        else if (FIFOClr)                r_errCnt <= '0;
        else if (w_pushErr && !w_popErr) r_errCnt <= r_errCnt + PW'(1);
        else if (w_popErr && !w_pushErr) r_errCnt <= r_errCnt - PW'(1);
    end

    // Idle timeout: restarts on any FIFO activity or while empty, saturates at the limit.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn)                                  r_toCnt <= '0;
        else if (FIFOClr || w_push || w_pop || w_empty) r_toCnt <= '0;
        else if (r_toCnt != TIMEOUT_P)                r_toCnt <= r_toCnt + TW'(1);
    end

    // Sticky overrun; a new drop wins over a same-cycle status-read clear so it is never lost.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn)      r_overrun <= 1'b0;
        else if (FIFOClr) r_overrun <= 1'b0;
        else if (w_drop)  r_overrun <= 1'b1;
        else if (w_stReq) r_overrun <= 1'b0;
    end

    // Registered read data, zero on any cycle without a valid read.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) r_rdata <= '0;
        else         r_rdata <= w_rdNext;
    end

    assign dsp.DSP_RDATA = r_rdata;
    assign RxFIFO_Level  = w_level;
    assign RxFIFO_Empty  = w_empty;
    assign RxFIFO_Full   = w_full;
    assign RxTrig        = (w_level >= w_trigLvl);
    assign RxTimeout     = w_timeout;
    assign OverrunError  = r_overrun;
    assign ErrInFIFO     = (r_errCnt != '0);
endmodule

// File: tb/tb_uart_rx_fifo_ctrl_p.sv
// Self-checking bench for uart_rx_fifo_ctrl_p: directed scenarios plus a random mix,
// compared every cycle against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo_ctrl_p;
    localparam int         DATA_W      = 8;
    localparam int         DEPTH_LOG2  = 4;
    localparam int         DEPTH       = 16;
    localparam int         SYNC_STAGES = 2;
    localparam int         TIMEOUT_CYC = 16;
    localparam logic [3:0] RD_ADDR     = 4'h0;
    localparam logic [3:0] ST_ADDR     = 4'h1;

    logic        DSP_CLK = 1'b0;
    logic        RESETn;
    logic        FIFOEn;
    logic        FIFOClr;
    logic [1:0]  TrigSel;
    logic        RxDone;
    logic [7:0]  RxData;
    logic [2:0]  RxErr;
    logic [4:0]  RxFIFO_Level;
    logic        RxFIFO_Empty;
    logic        RxFIFO_Full;
    logic        RxTrig;
    logic        RxTimeout;
    logic        OverrunError;
    logic        ErrInFIFO;

    uart_rx_fifo_ctrl_p_if dsp ();

    uart_rx_fifo_ctrl_p #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC), .RD_ADDR(RD_ADDR), .ST_ADDR(ST_ADDR)
    ) dut (
        .DSP_CLK(DSP_CLK), .RESETn(RESETn), .dsp(dsp),
        .FIFOEn(FIFOEn), .FIFOClr(FIFOClr), .TrigSel(TrigSel),
        .RxDone(RxDone), .RxData(RxData), .RxErr(RxErr),
        .RxFIFO_Level(RxFIFO_Level), .RxFIFO_Empty(RxFIFO_Empty), .RxFIFO_Full(RxFIFO_Full),
        .RxTrig(RxTrig), .RxTimeout(RxTimeout), .OverrunError(OverrunError), .ErrInFIFO(ErrInFIFO)
    );

    always #5 DSP_CLK = ~DSP_CLK;

    // Reference model state: queue of {err,data}, sticky overrun, idle cycles, RxDone run length.
    logic [10:0] modelQ[$];
    bit          modelOvr;
    int          modelIdle;
    int          rxRun;
    logic [31:0] expRdata;
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int effDepth();
        return FIFOEn ? DEPTH : 1;
    endfunction

    function automatic int trigLevel();
        if (!FIFOEn) return 1;
        case (TrigSel)
            2'd0:    return 1;
            2'd1:    return DEPTH / 4;
            2'd2:    return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    function automatic bit anyErr();
        foreach (modelQ[i]) if (modelQ[i][10:8] != 3'b000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] statusWord();
        logic [31:0] w;
        int n;
        n = modelQ.size();
        w = '0;
        w[8:0] = 9'(n);
        w[9]   = (n == 0);
        w[10]  = (n >= effDepth());
        w[11]  = (n >= trigLevel());
        w[12]  = anyErr();
        w[13]  = (modelIdle == TIMEOUT_CYC) && (n != 0);
        w[14]  = modelOvr;
        return w;
    endfunction

    function automatic logic [31:0] statusOut();
        return {17'b0, OverrunError, RxTimeout, ErrInFIFO, RxTrig, RxFIFO_Full, RxFIFO_Empty,
                4'b0, RxFIFO_Level};
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelOvr  = 1'b0;
        modelIdle = 0;
        rxRun     = 0;
        expRdata  = '0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ":status"}, statusOut(), statusWord());
        check({tag, ":rdata"}, dsp.DSP_RDATA, expRdata);
    endtask

    // One clock: the model consumes the inputs presented this cycle, then outputs are compared.
    task automatic tick();
        bit popReq, stReq, pushReq, popOk, pushOk, wasEmpty;
        int n;
        rxRun    = RxDone ? rxRun + 1 : 0;
        pushReq  = (rxRun == SYNC_STAGES + 1);
        popReq   = !dsp.DSP_CEn && dsp.DSP_WEn && (dsp.DSP_ADDR == RD_ADDR);
        stReq    = !dsp.DSP_CEn && dsp.DSP_WEn && (dsp.DSP_ADDR == ST_ADDR);
        n        = modelQ.size();
        wasEmpty = (n == 0);
        expRdata = '0;
        if (stReq) expRdata = statusWord();
        if (FIFOClr) begin
            modelQ.delete();
            modelOvr  = 1'b0;
            modelIdle = 0;
        end else begin
            popOk  = popReq && !wasEmpty;
            pushOk = pushReq && ((n < effDepth()) || popOk);
            if (stReq) modelOvr = 1'b0;
            if (popOk) expRdata = {1'b1, 20'b0, modelQ.pop_front()};
            if (pushOk) modelQ.push_back({RxErr, RxData});
            if (pushReq && !pushOk) modelOvr = 1'b1;
            if (pushOk || popOk || wasEmpty) modelIdle = 0;
            else if (modelIdle < TIMEOUT_CYC) modelIdle = modelIdle + 1;
        end
        @(posedge DSP_CLK);
        @(negedge DSP_CLK);
        checkOutput("cycle");
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Raise RxDone long enough to push; optionally pop or flush in the push cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] e, input bit popAtPush,
                                 input bit clrAtPush);
        RxDone = 1'b1;
        RxData = d;
        RxErr  = e;
        tick();
        tick();
        if (popAtPush) begin
            dsp.DSP_CEn  = 1'b0;
            dsp.DSP_WEn  = 1'b1;
            dsp.DSP_ADDR = RD_ADDR;
        end
        FIFOClr = clrAtPush;
        tick();
        dsp.DSP_CEn = 1'b1;
        FIFOClr     = 1'b0;
        RxDone      = 1'b0;
        idle(3);
    endtask

    task automatic readReg(input logic [3:0] addr);
        dsp.DSP_CEn  = 1'b0;
        dsp.DSP_WEn  = 1'b1;
        dsp.DSP_ADDR = addr;
        tick();
        dsp.DSP_CEn  = 1'b1;
    endtask

    initial begin
        int op;
        RESETn = 1'b0; FIFOEn = 1'b1; FIFOClr = 1'b0; TrigSel = 2'd0;
        RxDone = 1'b0; RxData = '0; RxErr = '0;
        dsp.DSP_CEn = 1'b1; dsp.DSP_WEn = 1'b1; dsp.DSP_ADDR = RD_ADDR;
        modelReset();
        repeat (3) @(negedge DSP_CLK);
        checkOutput("reset");
        check("resetStatus", statusOut(), 32'h0000_0200);
        RESETn = 1'b1;
        tick();

        // Three characters, the middle one with a parity error.
        $display("[TB] basic push/pop");
        applyStimulus(8'h41, 3'b000, 1'b0, 1'b0);
        applyStimulus(8'h42, 3'b001, 1'b0, 1'b0);
        applyStimulus(8'h43, 3'b000, 1'b0, 1'b0);
        check("level3", 32'(RxFIFO_Level), 32'd3);
        check("errIn3", 32'(ErrInFIFO), 32'd1);
        readReg(RD_ADDR);
        check("pop41", dsp.DSP_RDATA, 32'h8000_0041);
        readReg(RD_ADDR);
        check("pop42", dsp.DSP_RDATA, 32'h8000_0142);
        check("errCleared", 32'(ErrInFIFO), 32'd0);
        readReg(RD_ADDR);
        check("pop43", dsp.DSP_RDATA, 32'h8000_0043);
        dsp.DSP_CEn = 1'b0; dsp.DSP_WEn = 1'b0;
        tick();
        dsp.DSP_CEn = 1'b1; dsp.DSP_WEn = 1'b1;
        readReg(RD_ADDR);
        check("popEmpty", dsp.DSP_RDATA, 32'h0);

        // Overfill by one, then drain in order.
        $display("[TB] overrun");
        for (int i = 1; i <= 17; i++) applyStimulus(8'(i), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        check("fullAfter17", 32'(RxFIFO_Full), 32'd1);
        check("ovrSet", 32'(OverrunError), 32'd1);
        readReg(ST_ADDR);
        check("statusBit14", 32'(dsp.DSP_RDATA[14]), 32'd1);
        check("ovrCleared", 32'(OverrunError), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            readReg(RD_ADDR);
            check("drainOrder", 32'(dsp.DSP_RDATA[7:0]), 32'(i));
        end

        // Simultaneous push and pop on a full and on an empty FIFO.
        $display("[TB] push+pop same cycle");
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 3'b000, 1'b0, 1'b0);
        applyStimulus(8'hAA, 3'b000, 1'b1, 1'b0);
        check("fullPushPopLevel", 32'(RxFIFO_Level), 32'd16);
        check("fullPushPopOvr", 32'(OverrunError), 32'd0);
        for (int i = 0; i < 16; i++) readReg(RD_ADDR);
        check("newestLast", 32'(dsp.DSP_RDATA[7:0]), 32'hAA);
        applyStimulus(8'h55, 3'b000, 1'b1, 1'b0);
        check("emptyPushPopLevel", 32'(RxFIFO_Level), 32'd1);
        readReg(RD_ADDR);

        // Trigger at half depth, then depth-1 mode.
        $display("[TB] trigger and non-FIFO mode");
        TrigSel = 2'd2;
        for (int i = 0; i < 7; i++) applyStimulus(8'($urandom), 3'b000, 1'b0, 1'b0);
        check("trig7", 32'(RxTrig), 32'd0);
        applyStimulus(8'h08, 3'b000, 1'b0, 1'b0);
        check("trig8", 32'(RxTrig), 32'd1);
        for (int i = 0; i < 8; i++) readReg(RD_ADDR);
        FIFOEn = 1'b0;
        applyStimulus(8'h61, 3'b000, 1'b0, 1'b0);
        check("nonFifoFull", 32'(RxFIFO_Full), 32'd1);
        check("nonFifoTrig", 32'(RxTrig), 32'd1);
        applyStimulus(8'h62, 3'b000, 1'b0, 1'b0);
        check("nonFifoOvr", 32'(OverrunError), 32'd1);
        readReg(ST_ADDR);
        readReg(RD_ADDR);
        check("nonFifoPop", dsp.DSP_RDATA, 32'h8000_0061);
        FIFOEn = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 3'($urandom), 1'b0, 1'b0);
        FIFOEn = 1'b0;
        tick();
        check("fifoEnDropFull", 32'(RxFIFO_Full), 32'd1);
        for (int i = 0; i < 3; i++) readReg(RD_ADDR);
        FIFOEn = 1'b1;

        // Idle timeout counts 16 cycles from the push.
        $display("[TB] timeout");
        applyStimulus(8'h77, 3'b000, 1'b0, 1'b0);
        idle(12);
        check("timeout15", 32'(RxTimeout), 32'd0);
        idle(1);
        check("timeout16", 32'(RxTimeout), 32'd1);
        readReg(RD_ADDR);
        check("timeoutPopClr", 32'(RxTimeout), 32'd0);
        idle(20);
        check("timeoutStaysLow", 32'(RxTimeout), 32'd0);

        // Flush beats a same-cycle push; long RxDone gives one push.
        $display("[TB] flush and held RxDone");
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 3'($urandom), 1'b0, 1'b0);
        applyStimulus(8'h99, 3'b010, 1'b0, 1'b1);
        check("flushLevel", 32'(RxFIFO_Level), 32'd0);
        check("flushEmpty", 32'(RxFIFO_Empty), 32'd1);
        RxDone = 1'b1; RxData = 8'h3C; RxErr = 3'b100;
        idle(12);
        RxDone = 1'b0;
        idle(3);
        check("heldOnePush", 32'(RxFIFO_Level), 32'd1);
        readReg(RD_ADDR);
        check("heldData", dsp.DSP_RDATA, 32'h8000_043C);

        // Random mix of pushes, pops, status reads, idles and flushes.
        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 6);
            TrigSel = 2'($urandom_range(0, 3));
            case (op)
                0, 1, 2: applyStimulus(8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                3:       readReg(RD_ADDR);
                4:       readReg(ST_ADDR);
                5:       idle($urandom_range(1, 20));
                default: begin
                    FIFOClr = ($urandom_range(0, 3) == 0);
                    tick();
                    FIFOClr = 1'b0;
                end
            endcase
        end

        // Asynchronous reset in the middle of activity.
        $display("[TB] async reset");
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 3'b001, 1'b0, 1'b0);
        RxDone = 1'b1;
        readReg(ST_ADDR);
        #2 RESETn = 1'b0;
        #1;
        modelReset();
        check("asyncRstStatus", statusOut(), 32'h0000_0200);
        check("asyncRstRdata", dsp.DSP_RDATA, 32'h0);
        RxDone = 1'b0;
        @(negedge DSP_CLK);
        RESETn = 1'b1;
        idle(4);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
